// File: rtl/hilo_div_ctrl_pkg.sv
// Shared types and defaults for the HI/LO divide sequencer.
// Timeout defaults exist only when DIV_TIMEOUT_EN is defined.
package hilo_div_ctrl_pkg;

    localparam int unsigned DIV_WIDTH = 32;

`ifdef DIV_TIMEOUT_EN
    localparam int unsigned DIV_TIMEOUT_CYCLES = 40;
    localparam int unsigned DIV_CNT_W          = 6;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } div_state_e;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural register pair: MTHI/MTLO write port plus divide-result
// commit port; a commit wins over an MT write in the same cycle.
module hilo_regs
    import hilo_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             mt_hi_we_i,
    input  logic             mt_lo_we_i,
    input  logic [WIDTH-1:0] mt_data_i,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] commit_hi_i,
    input  logic [WIDTH-1:0] commit_lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit_i) begin
            hi_d = commit_hi_i;
            lo_d = commit_lo_i;
        end else begin
            if (mt_hi_we_i) hi_d = mt_data_i;
            if (mt_lo_we_i) lo_d = mt_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/hilo_div_ctrl.sv
// Sequencer between the control unit and the multicycle signed divider; owns HI/LO.
// Optional WAIT timeout watchdog is built when DIV_TIMEOUT_EN is defined.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
`ifdef DIV_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = DIV_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DIV_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0_exc,
    output logic             div_timeout,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_start,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_done,
    input  logic             div_by_zero
);

    div_state_e       state_q;
    logic             op_ready_q;
    logic             busy_q;
    logic             div_start_q;
    logic             div0_exc_q;
    logic [WIDTH-1:0] div_a_q;
    logic [WIDTH-1:0] div_b_q;
    logic             commit;
    logic             mt_hi_we;
    logic             mt_lo_we;

    // MT writes only land while idle; the result commit needs a clean done.
    assign mt_hi_we = hi_we & (state_q == ST_IDLE);
    assign mt_lo_we = lo_we & (state_q == ST_IDLE);
    assign commit   = (state_q == ST_WAIT) & div_done & ~div_by_zero;

`ifdef DIV_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             div_timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            div0_exc_q  <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
`ifdef DIV_TIMEOUT_EN
            cnt_q         <= '0;
            div_timeout_q <= 1'b0;
`endif
        end else begin
            div_start_q <= 1'b0;
            div0_exc_q  <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            div_timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        div_a_q     <= op_a;
                        div_b_q     <= op_b;
                        div_start_q <= 1'b1;
                        op_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                // Divider outputs are stale from the previous op here.
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
`ifdef DIV_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                ST_WAIT: begin
                    if (div_done) begin
                        div0_exc_q <= div_by_zero;
                        op_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        div_timeout_q <= 1'b1;
                        op_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    op_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    hilo_regs #(
        .WIDTH(WIDTH)
    ) u_hilo_regs (
        .clk        (clk),
        .rst_ni     (reset),
        .mt_hi_we_i (mt_hi_we),
        .mt_lo_we_i (mt_lo_we),
        .mt_data_i  (wdata),
        .commit_i   (commit),
        .commit_hi_i(div_remainder),
        .commit_lo_i(div_quotient),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    assign op_ready  = op_ready_q;
    assign busy      = busy_q;
    assign div_start = div_start_q;
    assign div0_exc  = div0_exc_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

`ifdef DIV_TIMEOUT_EN
    assign div_timeout = div_timeout_q;
`else
    assign div_timeout = 1'b0;
`endif

endmodule
